serial_chunk_adder: RTL

Parametrised multi-cycle adder/subtractor. It generalises the single-bit full adder to WIDTH-bit operands. Each cycle it adds CHUNK bits, LSB chunk first, and holds the carry in a register between chunks. It trades latency for area on wide datapaths. Operands and results move over valid/ready handshakes, so the block sits directly between pipeline stages.

---
 rtl/serial_chunk_adder.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// with the carry held in a register between chunks and valid/ready on both sides.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;

  // Current chunk add; msb_cin recovers the carry into the top bit of the chunk,
  // which on the last chunk is the carry into bit WIDTH-1.
  always_comb begin
    shamt     = 32'(idx) * 32'(CHUNK);
    a_chunk   = CHUNK'(areg >> shamt);
    b_chunk   = CHUNK'(breg >> shamt);
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry);
    res_next  = res | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);
    msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            res   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= chunk_sum[CHUNK];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            sum   <= res_next;
            cout  <= chunk_sum[CHUNK];
            ovf   <= msb_cin ^ chunk_sum[CHUNK];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
